// File: rtl/alu_pkg.sv
// Shared ALU select codes and sequencer state type for alu_exec_unit.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic alu_is_shift(input logic [3:0] sel);
        return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle AND/OR/ADD/SUB datapath; anything else reports legal=0 with y=0.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] y,
    output logic             legal
);

    always_comb begin
        y     = '0;
        legal = 1'b1;
        case (alu_sel)
            ALU_AND: y = op_a & op_b;
            ALU_OR:  y = op_a | op_b;
            ALU_ADD: y = op_a + op_b;
            ALU_SUB: y = op_a - op_b;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Sequenced ALU: single-cycle logic/arith via alu_core, bit-serial shifts when
// ALU_EXEC_SHIFT_EN is defined (otherwise shift codes report illegal).
//
// state    | meaning
// ST_IDLE  | ready to accept a request
// ST_SHIFT | shifting result_q one bit per cycle, cnt_q bits remaining
// ST_DONE  | result held until consumer takes it
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] core_y;
    logic             core_legal;

`ifdef ALU_EXEC_SHIFT_EN
    logic [4:0] cnt_q, cnt_d;
    logic [3:0] sel_q, sel_d;
`endif

    alu_core #(.WIDTH(WIDTH)) u_core (
        .alu_sel (alu_sel),
        .op_a    (op_a),
        .op_b    (op_b),
        .y       (core_y),
        .legal   (core_legal)
    );

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
`ifdef ALU_EXEC_SHIFT_EN
        cnt_d     = cnt_q;
        sel_d     = sel_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d   = ST_DONE;
                    result_d  = core_y;
                    illegal_d = !core_legal;
`ifdef ALU_EXEC_SHIFT_EN
                    // shift preloads op_a; shamt 0 completes immediately
                    if (alu_is_shift(alu_sel)) begin
                        illegal_d = 1'b0;
                        result_d  = op_a;
                        sel_d     = alu_sel;
                        cnt_d     = op_b[4:0];
                        if (op_b[4:0] != 5'd0) state_d = ST_SHIFT;
                    end
`endif
                end
            end
`ifdef ALU_EXEC_SHIFT_EN
            ST_SHIFT: begin
                case (sel_q)
                    ALU_SLL: result_d = {result_q[WIDTH-2:0], 1'b0};
                    ALU_SRL: result_d = {1'b0, result_q[WIDTH-1:1]};
                    default: result_d = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
                endcase
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
`ifdef ALU_EXEC_SHIFT_EN
            cnt_q     <= 5'd0;
            sel_q     <= ALU_SLL;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
`ifdef ALU_EXEC_SHIFT_EN
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = out_valid && (result_q == '0);
    assign illegal   = out_valid && illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit; follows ALU_EXEC_SHIFT_EN to pick shift expectations.
module tb_alu_exec_unit;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        illegal;
        int          lat;
    } exp_t;

`ifdef ALU_EXEC_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_sel = 4'h0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_sel   (alu_sel),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   sh;
        sh        = int'(b[4:0]);
        e.res     = '0;
        e.illegal = 1'b0;
        e.lat     = 1;
        case (sel)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0010: e.res = a + b;
            4'b0110: e.res = a - b;
            4'b1000, 4'b1001, 4'b1010: begin
                if (SHIFT_EN) begin
                    e.lat = sh + 1;
                    if (sel == 4'b1000)      e.res = a << sh;
                    else if (sel == 4'b1001) e.res = a >> sh;
                    else                     e.res = 32'($signed(a) >>> sh);
                end else begin
                    e.illegal = 1'b1;
                end
            end
            default: e.illegal = 1'b1;
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // issue one op, optionally toggling in_valid while busy and stalling out_ready
    task automatic exec(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input int stall, input bit noise);
        exp_t e;
        int   lat;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        alu_sel   = sel;
        op_a      = a;
        op_b      = b;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        sb.push_back(model(sel, a, b));
        in_valid = noise;
        alu_sel  = 4'b0010;
        op_a     = $urandom;
        op_b     = $urandom;
        lat = 1;
        while (!out_valid && lat < 64) begin
            chk("busy_in_ready", 32'(in_ready), 32'd0);
            chk("busy_zero", 32'(zero), 32'd0);
            in_valid = noise & lat[0];
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            chk("out_valid_timeout", 32'(out_valid), 32'd1);
            void'(sb.pop_front());
            in_valid = 1'b0;
            return;
        end
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("zero", 32'(zero), 32'(e.zero));
        chk("illegal", 32'(illegal), 32'(e.illegal));
        chk("latency", 32'(lat), 32'(e.lat));
        chk("done_in_ready", 32'(in_ready), 32'd0);
        in_valid = noise;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_result", result, e.res);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("exit_valid", 32'(out_valid), 32'd0);
        chk("exit_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [3:0] codes [8];
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1000, 4'b1001, 4'b1010, 4'b1100};

        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        exec(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 0, 1'b0);
        exec(4'b0110, 32'h0000_0005, 32'h0000_0005, 0, 1'b0);
        exec(4'b0110, 32'h0000_0000, 32'h0000_0001, 0, 1'b0);
        exec(4'b1010, 32'h8000_0000, 32'h0000_0004, 0, 1'b1);
        exec(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 3, 1'b1);
        exec(4'b0001, 32'h0000_0000, 32'h0000_0000, 0, 1'b0);
        exec(4'b1111, 32'h1234_5678, 32'h0000_0001, 0, 1'b0);
        exec(4'b1000, 32'h0000_0001, 32'h0000_0003, 0, 1'b0);
        exec(4'b1001, 32'h8000_0000, 32'h0000_001F, 0, 1'b0);
        exec(4'b1010, 32'h8765_4321, 32'h0000_001F, 2, 1'b0);
        exec(4'b1000, 32'hDEAD_BEEF, 32'h0000_0020, 0, 1'b0);
        exec(4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1);

        for (int n = 0; n < 24; n++)
            exec(codes[$urandom_range(0, 7)], $urandom, $urandom, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

        // reset mid-operation: SLL by 20, held in SHIFT (or DONE when shifts are off)
        alu_sel   = 4'b1000;
        op_a      = 32'h0000_0001;
        op_b      = 32'd20;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_illegal", 32'(illegal), 32'd0);
        chk("midrst_result", result, 32'd0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("postrst_out_valid", 32'(out_valid), 32'd0);
        exec(4'b0010, 32'd2, 32'd3, 0, 1'b0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  unit can accept a request.
REQ-006 alu_sel  input  4  operation select from ALU control: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1000 SLL, 1001 SRL, 1010 SRA.
REQ-007 op_a  input  WIDTH  first operand.
REQ-008 op_b  input  WIDTH  second operand; op_b[4:0] is the shift amount for shift ops.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  WIDTH  operation result.
REQ-012 zero  output  1  high when result equals 0.
REQ-013 illegal  output  1  high with out_valid when alu_sel was not a supported code.

Function
REQ-014 States: IDLE, SHIFT, DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 Accept occurs on a rising edge with in_valid && in_ready; operands and alu_sel SHALL be captured at accept.
REQ-016 AND/OR/ADD/SUB: IDLE -> DONE at accept; out_valid SHALL rise the cycle after accept (latency 1).
REQ-017 ADD/SUB SHALL wrap modulo 2^WIDTH; no carry or overflow output.
REQ-018 Shift with shamt 0: IDLE -> DONE, result = op_a, latency 1.
REQ-019 Shift with shamt N>0: IDLE -> SHIFT, one bit position per cycle, N cycles in SHIFT, then DONE; out_valid SHALL rise N+1 cycles after accept.
REQ-020 SRA SHALL replicate op_a[WIDTH-1] into vacated bits; SLL/SRL SHALL fill with 0.
REQ-021 Unsupported alu_sel: IDLE -> DONE, result 0, zero 1, illegal 1, latency 1.
REQ-022 DONE SHALL hold result, zero, illegal, out_valid stable until out_valid && out_ready, then return to IDLE on that edge.
REQ-023 in_valid during SHIFT or DONE SHALL be ignored (not accepted, not queued).
REQ-024 Throughput: at most one operation per two cycles (no accept in the DONE-exit cycle).
REQ-025 zero and illegal SHALL be 0 whenever out_valid is 0.

Reset
REQ-026 rst_n low SHALL force IDLE immediately, regardless of state, aborting any in-progress shift.
REQ-027 Reset values: in_ready 1 (after reset deassert), out_valid 0, result 0, zero 0, illegal 0, shift counter 0.
REQ-028 A result pending in DONE at reset SHALL be discarded.

Configuration
REQ-029 Macro ALU_EXEC_SHIFT_EN: when defined, shift codes 1000/1001/1010 behave per REQ-018..020.
REQ-030 When ALU_EXEC_SHIFT_EN is undefined, shift codes SHALL be treated as unsupported (REQ-021), SHIFT state and shift counter SHALL not be instantiated.

Structure
REQ-031 Package alu_pkg SHALL hold the 4-bit alu_sel code constants and the state enum type.
REQ-032 Sub-module alu_core SHALL implement the single-cycle AND/OR/ADD/SUB datapath combinationally; sequencing and shifting stay in alu_exec_unit.

Verification
REQ-033 ADD 0x7FFFFFFF + 0x00000001, out_ready 1 -> out_valid one cycle after accept, result 0x80000000, zero 0.
REQ-034 SUB 0x00000005 - 0x00000005 -> result 0, zero 1; SUB 0 - 1 -> 0xFFFFFFFF.
REQ-035 SRA op_a 0x80000000, op_b 4 (shift enabled) -> out_valid 5 cycles after accept, result 0xF8000000; in_valid pulses during SHIFT not accepted.
REQ-036 AND result held with out_ready 0 for 3 cycles -> result/out_valid stable, in_ready 0; out_ready 1 -> IDLE next cycle.
REQ-037 alu_sel 1111 -> result 0, zero 1, illegal 1; with macro undefined, SLL 0x1 by 3 -> illegal 1, result 0.
REQ-038 rst_n asserted mid-SHIFT (SLL by 20, after 5 cycles) -> out_valid 0 immediately, IDLE after release, next ADD 2+3 returns 5.
